// File: rtl/vec_alu_pkg.sv
// Shared types and per-lane arithmetic for the strip-mined vector ALU.
// Build option: VEC_ALU_SAT_EN turns ADD/SUB into unsigned saturating ops.
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Lanes are evaluated at a fixed wide width and masked down to the element width.
  localparam int LW = 64;

  typedef struct packed {
    logic          sat;
    logic [LW-1:0] res;
  } lane_res_t;

  function automatic lane_res_t lane_op(alu_op_e op, logic [LW-1:0] a, logic [LW-1:0] b,
                                        logic [5:0] shamt, int unsigned n);
    lane_res_t     r;
    logic [LW-1:0] mask;
`ifdef VEC_ALU_SAT_EN
    logic [LW:0]   sum;
`endif
    mask = (n >= LW) ? '1 : ((LW'(1) << n) - LW'(1));
    r    = '0;
    case (op)
      OP_ADD: begin
`ifdef VEC_ALU_SAT_EN
        sum   = {1'b0, a} + {1'b0, b};
        r.res = sum[LW-1:0] & mask;
        if (sum > {1'b0, mask}) begin
          r.res = mask;
          r.sat = 1'b1;
        end
`else
        r.res = (a + b) & mask;
`endif
      end
      OP_SUB: begin
`ifdef VEC_ALU_SAT_EN
        if (b > a) begin
          r.res = '0;
          r.sat = 1'b1;
        end else begin
          r.res = (a - b) & mask;
        end
`else
        r.res = (a - b) & mask;
`endif
      end
      OP_AND:  r.res = a & b & mask;
      OP_OR:   r.res = (a | b) & mask;
      OP_XOR:  r.res = (a ^ b) & mask;
      OP_SLL:  r.res = (a << shamt) & mask;
      OP_SRL:  r.res = (a & mask) >> shamt;
      default: r.res = b & mask;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vec_alu_seq_if.sv
// Operation/result handshake bundle for vec_alu_seq; SatFlag exists only with VEC_ALU_SAT_EN.
interface vec_alu_seq_if #(
  parameter int N     = 8,
  parameter int LANES = 16,
  parameter int WA_W  = 4
);
  logic                 Flush;
  logic                 InValid;
  logic                 InReady;
  logic [2:0]           ALUControl;
  logic                 UseImm;
  logic [LANES*N-1:0]   SrcA;
  logic [LANES*N-1:0]   SrcB;
  logic [N-1:0]         Imm;
  logic [WA_W-1:0]      WA3;
  logic                 OutValid;
  logic                 OutReady;
  logic [LANES*N-1:0]   Result;
  logic [WA_W-1:0]      WA3Out;
  logic                 Zero;
  logic                 Busy;
`ifdef VEC_ALU_SAT_EN
  logic                 SatFlag;
`endif

  modport slave (
    input  Flush, InValid, ALUControl, UseImm, SrcA, SrcB, Imm, WA3, OutReady,
    output InReady, OutValid, Result, WA3Out, Zero, Busy
`ifdef VEC_ALU_SAT_EN
    , output SatFlag
`endif
  );

  modport master (
    output Flush, InValid, ALUControl, UseImm, SrcA, SrcB, Imm, WA3, OutReady,
    input  InReady, OutValid, Result, WA3Out, Zero, Busy
`ifdef VEC_ALU_SAT_EN
    , input SatFlag
`endif
  );
endinterface

// File: rtl/vec_lane_slice.sv
// Combinational compute of the PAR lanes addressed by the current beat.
module vec_lane_slice
  import vec_alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int LANES = 16,
  parameter int PAR   = 4,
  parameter int BW    = 2
) (
  input  alu_op_e            op,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  input  logic [BW-1:0]      beat,
  output logic [PAR*N-1:0]   res,
  output logic               sat
);
  localparam int SHW = (N > 1) ? $clog2(N) : 1;

  logic [PAR-1:0] lane_sat;

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    logic [N-1:0]    la;
    logic [N-1:0]    lb;
    lane_res_t       r;
    logic [LW-N-1:0] hi_unused;

    always_comb begin
      la = a[(int'(beat) * PAR + i) * N +: N];
      lb = b[(int'(beat) * PAR + i) * N +: N];
      r  = lane_op(op, LW'(la), LW'(lb), 6'(lb[SHW-1:0]), N);
    end

    assign res[i*N +: N] = r.res[N-1:0];
    assign hi_unused     = r.res[LW-1:N];
    assign lane_sat[i]   = r.sat;
  end

  assign sat = |lane_sat;
endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: latches a LANES x N op, computes PAR lanes per beat, holds result.
// Build option: VEC_ALU_SAT_EN (saturating ADD/SUB plus SatFlag output).
module vec_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int LANES = 16,
  parameter int PAR   = 4,
  parameter int WA_W  = 4
) (
  input logic          CLK,
  input logic          RST,
  vec_alu_seq_if.slave io
);
  localparam int BEATS = LANES / PAR;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES % PAR != 0) begin : g_par_check
    $error("vec_alu_seq: LANES must be a multiple of PAR");
  end

  state_e             state;
  logic [BW-1:0]      beat;
  alu_op_e            op_q;
  logic [LANES*N-1:0] a_q;
  logic [LANES*N-1:0] b_q;
  logic [LANES*N-1:0] res_q;
  logic [LANES*N-1:0] res_nxt;
  logic [WA_W-1:0]    wa_q;
  logic               zero_q;
  logic [PAR*N-1:0]   slice_res;
  logic               slice_sat;
  logic               accept;
  logic               last_beat;

  // Flush blocks acceptance in the same cycle it aborts the current op.
  assign io.InReady = !io.Flush && (state == IDLE || (state == DONE && io.OutReady));
  assign accept     = io.InValid && io.InReady;
  assign last_beat  = (beat == BW'(BEATS - 1));

  vec_lane_slice #(.N(N), .LANES(LANES), .PAR(PAR), .BW(BW)) u_slice (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .beat (beat),
    .res  (slice_res),
    .sat  (slice_sat)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[int'(beat) * PAR * N +: PAR * N] = slice_res;
  end

`ifdef VEC_ALU_SAT_EN
  logic sat_q;
  assign io.SatFlag = sat_q;
`else
  logic sat_unused;
  assign sat_unused = slice_sat;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      beat   <= '0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      wa_q   <= '0;
      zero_q <= 1'b0;
`ifdef VEC_ALU_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else if (io.Flush) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      if (accept) begin
        op_q  <= alu_op_e'(io.ALUControl);
        a_q   <= io.SrcA;
        b_q   <= io.UseImm ? {LANES{io.Imm}} : io.SrcB;
        wa_q  <= io.WA3;
        beat  <= '0;
        state <= RUN;
      end
      case (state)
        RUN: begin
          res_q <= res_nxt;
`ifdef VEC_ALU_SAT_EN
          sat_q <= ((beat == '0) ? 1'b0 : sat_q) | slice_sat;
`endif
          if (last_beat) begin
            zero_q <= (res_nxt == '0);
            beat   <= '0;
            state  <= DONE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        DONE: if (io.OutReady && !accept) state <= IDLE;
        default: ;
      endcase
    end
  end

  assign io.OutValid = (state == DONE);
  assign io.Busy     = (state != IDLE);
  assign io.Result   = res_q;
  assign io.WA3Out   = wa_q;
  assign io.Zero     = zero_q;
endmodule
